// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared definitions for the read-only cache controller.
//   - state_t    : controller FSM states
//   - CNT_W      : width of the saturating hit/miss counters
//   - DEF_*      : default geometry (256 lines x 4 words) and derived widths
//   - offset_w() : word-offset width for a given words-per-line
//   - tag_w()    : tag width for a given index width and words-per-line
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_REQ,
        ST_REFILL,
        ST_RESPOND
    } state_t;

    localparam int ADDR_W      = 32;
    localparam int BYTE_OFF_W  = 2;
    localparam int CNT_W       = 21;

    function automatic int offset_w(input int wpl);
        return $clog2(wpl);
    endfunction

    function automatic int tag_w(input int index_w, input int wpl);
        return ADDR_W - index_w - $clog2(wpl) - BYTE_OFF_W;
    endfunction

    localparam int DEF_INDEX_W  = 8;
    localparam int DEF_WPL      = 4;
    localparam int DEF_OFFSET_W = offset_w(DEF_WPL);
    localparam int DEF_TAG_W    = tag_w(DEF_INDEX_W, DEF_WPL);

endpackage

// File: rtl/cache_line_store.sv
// cache_line_store
//   Valid bits, tags and line data for a direct-mapped cache.
//   Read port : i_rd_idx/i_rd_off sampled on the rising edge; o_rd_valid,
//               o_rd_tag and o_rd_word appear the following cycle.
//   Write port: i_wr_en writes one data word at {i_wr_idx, i_wr_off};
//               i_wr_tag_set writes the tag and sets the valid bit;
//               i_wr_inv clears the valid bit of i_wr_idx.
//   rst clears the valid bits only; tags and data are left untouched.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int  INDEX_W        = DEF_INDEX_W,
    parameter int  WORDS_PER_LINE = DEF_WPL,
    parameter int  TAG_W          = DEF_TAG_W,
    localparam int OFF_W          = offset_w(WORDS_PER_LINE)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_idx,
    input  logic [OFF_W-1:0]   i_rd_off,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [31:0]        o_rd_word,
    input  logic               i_wr_en,
    input  logic               i_wr_tag_set,
    input  logic               i_wr_inv,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic [OFF_W-1:0]   i_wr_off,
    input  logic [31:0]        i_wr_data,
    input  logic [TAG_W-1:0]   i_wr_tag
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES*WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_tag_set) begin
            r_valid[i_wr_idx] <= 1'b1;
        end else if (i_wr_inv) begin
            r_valid[i_wr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
        end
        if (i_wr_tag_set) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        o_rd_valid <= r_valid[i_rd_idx];
        o_rd_tag   <= r_tag[i_rd_idx];
        o_rd_word  <= r_data[{i_rd_idx, i_rd_off}];
    end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl
//   Direct-mapped, read-only cache controller with line refill from memory.
//   Requester : req_valid/req_ready/req_addr in; resp_valid (1-cycle pulse),
//               resp_data, resp_hit out.
//   Memory    : mem_req_valid/mem_req_ready/mem_req_addr line fetch, then
//               WORDS_PER_LINE beats on mem_rvalid/mem_rdata in ascending order.
//   Stats     : hits, misses - saturating counters.
//   clk/rst   : single clock, synchronous active-high reset.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int  INDEX_W        = DEF_INDEX_W,
    parameter int  WORDS_PER_LINE = DEF_WPL,
    localparam int OFF_W          = offset_w(WORDS_PER_LINE),
    localparam int TAG_W          = tag_w(INDEX_W, WORDS_PER_LINE)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic             resp_hit,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] misses
);

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
    localparam int               LINE_LSB  = OFF_W + BYTE_OFF_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             r_state;
    logic [31:0]        r_addr;
    logic [OFF_W-1:0]   r_beat;
    logic [31:0]        r_word;
    logic               r_hit;
    logic               r_resp_valid;
    logic [31:0]        r_resp_data;
    logic               r_resp_hit;
    logic               r_mem_req_valid;
    logic [31:0]        r_mem_req_addr;
    logic [CNT_W-1:0]   r_hits;
    logic [CNT_W-1:0]   r_misses;

    logic [INDEX_W-1:0] w_req_idx;
    logic [OFF_W-1:0]   w_req_off;
    logic [INDEX_W-1:0] w_addr_idx;
    logic [OFF_W-1:0]   w_addr_off;
    logic [TAG_W-1:0]   w_addr_tag;
    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [31:0]        w_rd_word;
    logic               w_hit;
    logic               w_wr_en;
    logic               w_wr_tag_set;
    logic               w_wr_inv;
    logic               w_unused_byte_bits;

    assign w_unused_byte_bits = ^{req_addr[1:0], r_addr[1:0]};

    // The read port always looks at the incoming address; the line read on
    // the accepting edge is what LOOKUP compares against.
    assign w_req_off  = req_addr[BYTE_OFF_W +: OFF_W];
    assign w_req_idx  = req_addr[LINE_LSB +: INDEX_W];
    assign w_addr_off = r_addr[BYTE_OFF_W +: OFF_W];
    assign w_addr_idx = r_addr[LINE_LSB +: INDEX_W];
    assign w_addr_tag = r_addr[ADDR_W-1 -: TAG_W];

    assign w_hit = w_rd_valid && (w_rd_tag == w_addr_tag);

    // The last beat writes data, tag and valid together so the line becomes
    // valid exactly when it is complete.
    assign w_wr_inv     = !rst && (r_state == ST_LOOKUP) && !w_hit;
    assign w_wr_en      = !rst && (r_state == ST_REFILL) && mem_rvalid;
    assign w_wr_tag_set = w_wr_en && (r_beat == LAST_BEAT);

    cache_line_store #(
        .INDEX_W        (INDEX_W),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_store (
        .clk          (clk),
        .rst          (rst),
        .i_rd_idx     (w_req_idx),
        .i_rd_off     (w_req_off),
        .o_rd_valid   (w_rd_valid),
        .o_rd_tag     (w_rd_tag),
        .o_rd_word    (w_rd_word),
        .i_wr_en      (w_wr_en),
        .i_wr_tag_set (w_wr_tag_set),
        .i_wr_inv     (w_wr_inv),
        .i_wr_idx     (w_addr_idx),
        .i_wr_off     (r_beat),
        .i_wr_data    (mem_rdata),
        .i_wr_tag     (w_addr_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_beat          <= '0;
            r_resp_valid    <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_hits          <= '0;
            r_misses        <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_hits  <= sat_inc(r_hits);
                        r_word  <= w_rd_word;
                        r_hit   <= 1'b1;
                        r_state <= ST_RESPOND;
                    end else begin
                        r_misses        <= sat_inc(r_misses);
                        r_hit           <= 1'b0;
                        r_beat          <= '0;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_addr  <= {r_addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
                        r_state         <= ST_MEM_REQ;
                    end
                end
                ST_MEM_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (mem_rvalid) begin
                        // Capture the requested word as it streams past, so
                        // a word on the final beat needs no extra read.
                        if (r_beat == w_addr_off) begin
                            r_word <= mem_rdata;
                        end
                        if (r_beat == LAST_BEAT) begin
                            r_beat  <= '0;
                            r_state <= ST_RESPOND;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                ST_RESPOND: begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= r_word;
                    r_resp_hit   <= r_hit;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_data     = r_resp_data;
    assign resp_hit      = r_resp_hit;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign hits          = r_hits;
    assign misses        = r_misses;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl
//   Directed bench for cache_ctrl. A reference model (line valid/tag table,
//   counters, a fixed memory image) predicts each response; one process
//   compares every response pulse against it, and literal checks pin the
//   model at key points.
module tb_cache_ctrl;

    localparam int WPL  = 4;
    localparam int CMAX = (1 << 21) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [20:0] hits;
    logic [20:0] misses;

    cache_ctrl #(
        .INDEX_W        (8),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_hit      (resp_hit),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .hits          (hits),
        .misses        (misses)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        int          hits;
        int          misses;
        int          due;
    } exp_t;

    exp_t        q[$];
    bit          mvalid [256];
    logic [19:0] mtag   [256];
    int          m_hits;
    int          m_misses;
    int          n_resp = 0;
    logic [31:0] last_data;
    logic        last_hit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory image: line 0x10 holds 0xA0..0xA3, every other word is its
    // address xor 0x5A000000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'h1) return 32'hA0 + {30'b0, w[3:2]};
        return 32'h5A00_0000 ^ w;
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            exp_t e;
            last_data = resp_data;
            last_hit  = resp_hit;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got resp_valid=1 data 0x%0h, expected no response", resp_data);
            end else begin
                e = q.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_hit", 32'(resp_hit), 32'(e.hit));
                check("hits", 32'(hits), 32'(e.hits));
                check("misses", 32'(misses), 32'(e.misses));
                if (e.due >= 0) check("hit_latency_cycle", 32'(cyc), 32'(e.due));
            end
            n_resp++;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] a, output bit h);
        int n;
        logic [7:0]  idx;
        logic [19:0] tg;
        n   = 0;
        idx = a[11:4];
        tg  = a[31:12];
        h   = 1'b0;
        req_addr  = a;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_accept: got req_ready=0 for 20 cycles, expected 1");
            req_valid = 1'b0;
            return;
        end
        h = mvalid[idx] && (mtag[idx] == tg);
        if (h) begin
            m_hits = sat(m_hits);
        end else begin
            m_misses    = sat(m_misses);
            mvalid[idx] = 1'b0;
        end
        q.push_back('{mem_word(a), h, m_hits, m_misses, h ? cyc + 3 : -1});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic serve(input logic [31:0] a, input int stall, input bit gaps, input int abort_after);
        int n;
        logic [31:0] line;
        n    = 0;
        line = {a[31:4], 4'b0};
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        if (!mem_req_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mem_req_wait: got mem_req_valid=0 for 20 cycles, expected 1");
            return;
        end
        check("mem_req_addr", mem_req_addr, line);
        for (int i = 0; i < stall; i++) begin
            check("stall_mem_req_valid", 32'(mem_req_valid), 32'd1);
            check("stall_mem_req_addr", mem_req_addr, line);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < WPL; b++) begin
            if (gaps && (b % 2 == 1)) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(line + 32'(4 * b));
            tick();
            mem_rvalid = 1'b0;
            if (abort_after == b + 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                model_clear();
                return;
            end
        end
        mvalid[a[11:4]] = 1'b1;
        mtag[a[11:4]]   = a[31:12];
    endtask

    task automatic wait_resp(input int n0);
        int n;
        n = 0;
        while (n_resp == n0 && n < 40) begin
            tick();
            n++;
        end
        if (n_resp == n0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_wait: got no resp_valid in 40 cycles, expected a response");
        end
    endtask

    task automatic rd(input logic [31:0] a, input int stall, input bit gaps);
        int n0;
        bit h;
        n0 = n_resp;
        issue(a, h);
        if (!h) serve(a, stall, gaps, 0);
        wait_resp(n0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        model_clear();
        repeat (3) tick();
        rst = 1'b0;

        // Reset state, first cycle after reset.
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_hits", 32'(hits), 32'd0);
        check("rst_misses", 32'(misses), 32'd0);

        rd(32'h0000_0010, 0, 1'b0);
        check("t1_data", last_data, 32'h0000_00A0);
        check("t1_hit", 32'(last_hit), 32'd0);
        check("t1_misses", 32'(misses), 32'd1);
        check("t1_hits", 32'(hits), 32'd0);

        rd(32'h0000_0014, 0, 1'b0);
        check("t2_data", last_data, 32'h0000_00A1);
        check("t2_hit", 32'(last_hit), 32'd1);
        check("t2_hits", 32'(hits), 32'd1);

        rd(32'h0000_1010, 0, 1'b1);
        check("t3_data", last_data, 32'h5A00_1010);
        check("t3_hit", 32'(last_hit), 32'd0);
        rd(32'h0000_0010, 0, 1'b0);
        check("t4_hit", 32'(last_hit), 32'd0);
        check("t4_misses", 32'(misses), 32'd3);

        rd(32'h0000_001C, 0, 1'b0);
        check("t5_data", last_data, 32'h0000_00A3);

        // Held memory handshake; requested word on the final beat.
        rd(32'h0000_002C, 5, 1'b0);
        check("t6_data", last_data, 32'h5A00_002C);
        check("t6_misses", 32'(misses), 32'd4);

        // Reset in the middle of a refill, then stray beats while idle.
        issue(32'h0000_0040, h);
        serve(32'h0000_0040, 0, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_0000 + 32'(i);
            tick();
            check("stray_req_ready", 32'(req_ready), 32'd1);
            check("stray_mem_req_valid", 32'(mem_req_valid), 32'd0);
            check("stray_resp_valid", 32'(resp_valid), 32'd0);
        end
        mem_rvalid = 1'b0;
        check("abort_hits", 32'(hits), 32'd0);
        check("abort_misses", 32'(misses), 32'd0);
        rd(32'h0000_0040, 0, 1'b0);
        check("t7_hit", 32'(last_hit), 32'd0);
        check("t7_data", last_data, 32'h5A00_0040);
        check("t7_misses", 32'(misses), 32'd1);
        rd(32'h0000_0010, 0, 1'b0);
        check("t7b_hit", 32'(last_hit), 32'd0);

        // Hit counter saturation.
        rd(32'h0000_0014, 0, 1'b0);
        force dut.r_hits = 21'h1FFFFE;
        m_hits = CMAX - 1;
        #1;
        release dut.r_hits;
        tick();
        for (int i = 0; i < 3; i++) rd(32'h0000_0018, 0, 1'b0);
        check("sat_hits", 32'(hits), 32'h001F_FFFF);
        check("sat_data", last_data, 32'h0000_00A2);

        repeat (3) tick();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter INDEX_W, default 8, number of line-index bits (2^INDEX_W lines).
REQ-002 Parameter WORDS_PER_LINE, default 4, 32-bit words per line; power of two, at least 2.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 req_valid  in  1  requester presents a read address.
REQ-006 req_ready  out  1  controller accepts a request this cycle.
REQ-007 req_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 resp_valid  out  1  one-cycle pulse; resp_data and resp_hit are valid.
REQ-009 resp_data  out  32  requested word.
REQ-010 resp_hit  out  1  1 = served from cache, 0 = served after refill.
REQ-011 mem_req_valid  out  1  line-fetch request to memory.
REQ-012 mem_req_ready  in  1  memory accepts the fetch.
REQ-013 mem_req_addr  out  32  line-aligned fetch address; low log2(WORDS_PER_LINE)+2 bits zero.
REQ-014 mem_rvalid  in  1  one refill beat present.
REQ-015 mem_rdata  in  32  refill word; beats arrive in ascending word order.
REQ-016 hits  out  21  saturating hit count.
REQ-017 misses  out  21  saturating miss count.

Function
REQ-018 Address split: word offset = addr[log2(WPL)+1:2]; index = next INDEX_W bits; tag = remaining upper bits.
REQ-019 The FSM shall have the states IDLE, LOOKUP, MEM_REQ, REFILL and RESPOND.
REQ-020 req_ready shall be 1 only in IDLE; a handshake latches req_addr and moves the FSM to LOOKUP.
REQ-021 In LOOKUP, a valid line with a matching tag shall count as a hit: increment hits and go to RESPOND with resp_hit=1.
REQ-022 In LOOKUP, a miss shall increment misses, invalidate the indexed line and go to MEM_REQ.
REQ-023 Hit latency: resp_valid shall assert 2 cycles after the accepting edge.
REQ-024 In MEM_REQ, mem_req_valid shall be 1 and mem_req_addr shall be stable until mem_req_ready; on handshake go to REFILL.
REQ-025 REFILL shall write each mem_rvalid beat to word 0..WPL-1 in order via a beat counter that wraps to 0.
REQ-026 After the last beat, REFILL shall set the tag and valid bit and go to RESPOND with resp_hit=0.
REQ-027 A miss response shall carry the requested word, including when that word arrives on the last beat.
REQ-028 RESPOND shall assert resp_valid for exactly one cycle and then return to IDLE; there is no response backpressure.
REQ-029 mem_rvalid outside REFILL shall be ignored and shall not change any state.
REQ-030 hits and misses shall saturate at 2^21-1 and shall not wrap.
REQ-031 Back-to-back requests shall be accepted no sooner than 3 cycles apart for hits.

Reset
REQ-032 On rst, the FSM shall go to IDLE, all valid bits shall clear, the counters shall be 0, and resp_valid and mem_req_valid shall be 0.
REQ-033 After rst, req_ready shall be 1 in the first cycle.
REQ-034 rst during MEM_REQ or REFILL shall abandon the fetch and leave the line invalid; later beats are ignored per REQ-029.
REQ-035 Data and tag arrays shall not be reset; only the valid bits shall be reset.

Structure
REQ-036 Package cache_pkg shall hold the FSM state enum, the derived width constants (offset, index, tag) and the counter width of 21.
REQ-037 Sub-module cache_line_store shall hold the valid, tag and data arrays, with one read port and one write port.

Verification
REQ-038 After reset, read 0x0000_0010 with a 4-beat refill of 0xA0..0xA3 -> resp_hit=0, resp_data=0xA0, misses=1, hits=0.
REQ-039 Repeat read of 0x0000_0014 -> resp_valid 2 cycles after acceptance, resp_hit=1, resp_data=0xA1, hits=1.
REQ-040 Read 0x0000_1010 (same index, different tag) -> miss and refill; then 0x0000_0010 misses again; misses=3.
REQ-041 Hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stay stable and req_ready stays 0 throughout.
REQ-042 Assert rst after the 2nd refill beat, then read the same address -> miss; stray mem_rvalid while IDLE changes nothing.
REQ-043 Force hits to 2^21-2, then issue 3 hits -> hits holds at 2^21-1.
